// File: rtl/alu_share_arbiter.sv
// Round-robin share of one combinational execute ALU between two requesters,
// with a one-entry valid/ready response buffer per requester.
module alu_share_arbiter #(
  parameter int WIDTH   = 32,
  parameter int NUM_REQ = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_srca,
  input  logic [NUM_REQ*WIDTH-1:0] req_srcb,
  input  logic [NUM_REQ*3-1:0]     req_aluctl,
  input  logic [NUM_REQ*3-1:0]     req_funct3,
  output logic [WIDTH-1:0]         alu_srca,
  output logic [WIDTH-1:0]         alu_srcb,
  output logic [2:0]               alu_ctl,
  output logic [2:0]               alu_funct3,
  input  logic [WIDTH-1:0]         alu_result,
  input  logic                     alu_zero,
  output logic [NUM_REQ-1:0]       rsp_valid,
  input  logic [NUM_REQ-1:0]       rsp_ready,
  output logic [NUM_REQ*WIDTH-1:0] rsp_result,
  output logic [NUM_REQ-1:0]       rsp_zero
);

  logic [NUM_REQ-1:0]       rsp_valid_q, rsp_valid_d;
  logic [NUM_REQ*WIDTH-1:0] rsp_result_q, rsp_result_d;
  logic [NUM_REQ-1:0]       rsp_zero_q, rsp_zero_d;
  logic                     last_grant_q, last_grant_d;
  logic [NUM_REQ-1:0]       slot_free, eligible, grant;

  // A draining slot counts as free so it can be refilled in the same cycle.
  always_comb begin
    slot_free = ~rsp_valid_q | rsp_ready;
    eligible  = reset ? '0 : (req_valid & slot_free);
    grant     = eligible;
    if (eligible == 2'b11) begin
      grant = last_grant_q ? 2'b01 : 2'b10;
    end
  end

  assign req_ready = grant;

  always_comb begin
    alu_srca   = '0;
    alu_srcb   = '0;
    alu_ctl    = 3'b000;
    alu_funct3 = 3'b010;
    if (grant[1]) begin
      alu_srca   = req_srca[WIDTH +: WIDTH];
      alu_srcb   = req_srcb[WIDTH +: WIDTH];
      alu_ctl    = req_aluctl[5:3];
      alu_funct3 = req_funct3[5:3];
    end else if (grant[0]) begin
      alu_srca   = req_srca[0 +: WIDTH];
      alu_srcb   = req_srcb[0 +: WIDTH];
      alu_ctl    = req_aluctl[2:0];
      alu_funct3 = req_funct3[2:0];
    end
  end

  always_comb begin
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_zero_d   = rsp_zero_q;
    last_grant_d = last_grant_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        rsp_valid_d[i]                = 1'b1;
        rsp_result_d[i*WIDTH +: WIDTH] = alu_result;
        rsp_zero_d[i]                 = alu_zero;
      end else if (rsp_ready[i]) begin
        rsp_valid_d[i] = 1'b0;
      end
    end
    if (grant[1]) begin
      last_grant_d = 1'b1;
    end else if (grant[0]) begin
      last_grant_d = 1'b0;
    end
  end

  // Reset pointer to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid_q  <= '0;
      rsp_result_q <= '0;
      rsp_zero_q   <= '0;
      last_grant_q <= 1'b1;
    end else begin
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_zero_q   <= rsp_zero_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_zero   = rsp_zero_q;

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares the single combinational execute-stage ALU between two requesters, e.g. the main pipeline lane and a secondary address/branch-compare unit.
- Round-robin arbitration picks at most one requester per cycle and drives the ALU inputs combinationally from that requester.
- The ALU result and zero flag are captured into a per-requester one-entry response buffer.
- Responses use a valid/ready handshake.

Parameters:
- WIDTH, 32, operand/result width; must match the ALU datapath.
- NUM_REQ, 2, number of requesters; fixed at 2 in this revision, and any other value is unsupported.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- req_valid  input  2  per-requester request valid; bit i = requester i
- req_ready  output  2  per-requester accept; a transfer occurs when req_valid[i] & req_ready[i] are both high
- req_srca  input  2*WIDTH  operand A; requester i in bits [i*WIDTH +: WIDTH]
- req_srcb  input  2*WIDTH  operand B, same packing as req_srca
- req_aluctl  input  6  3-bit ALU op per requester: 000 add, 001 sub, 010 and, 011 or, 100 slt, 101 xor
- req_funct3  input  6  3-bit branch-compare select per requester: 000 eq, 001 ne, 100 lt, 101 gt; others give zero=0
- alu_srca  output  WIDTH  to ALU SrcAE
- alu_srcb  output  WIDTH  to ALU SrcBE
- alu_ctl  output  3  to ALU ALUControlE
- alu_funct3  output  3  to ALU funct3E
- alu_result  input  WIDTH  from ALU ALUResult
- alu_zero  input  1  from ALU ZeroE
- rsp_valid  output  2  per-requester response valid
- rsp_ready  input  2  per-requester response accept
- rsp_result  output  2*WIDTH  buffered result per requester
- rsp_zero  output  2  buffered zero/compare flag per requester

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - Reset is synchronous and active-high; it is sampled on the rising edge of clk.
- Slot availability:
  - slot_free[i] = ~rsp_valid[i] | rsp_ready[i].
  - A draining slot may be refilled in the same cycle.
- Eligibility: eligible[i] = req_valid[i] & slot_free[i].
- Arbitration:
  - One-hot grant, combinational, within the same cycle.
  - Registered pointer last_grant (1 bit) holds the index of the most recent granted requester.
  - If both requesters are eligible, grant ~last_grant.
  - If only one is eligible, grant that one.
  - If neither is eligible, there is no grant.
- req_ready:
  - req_ready[i] = grant[i].
  - req_ready[i] may depend on req_valid[i]; requesters must not make req_valid depend on req_ready.
- ALU drive:
  - When grant[i] is high, alu_* = requester i's fields.
  - With no grant: alu_srca = 0, alu_srcb = 0, alu_ctl = 000, alu_funct3 = 010.
  - Idle ALU drive is deterministic.
- Capture:
  - On a clk edge with grant[i]: rsp_result[i] <= alu_result, rsp_zero[i] <= alu_zero, rsp_valid[i] <= 1.
- Drain: on an edge with rsp_valid[i] & rsp_ready[i] & ~grant[i], rsp_valid[i] <= 0.
- Response hold:
  - While rsp_valid[i] is high and rsp_ready[i] is low, rsp_result[i] and rsp_zero[i] are held stable.
  - That requester is not granted during this time.
- Latency:
  - Request accepted in cycle N gives rsp_valid high in cycle N+1.
  - Throughput is 1 op/cycle aggregate and 1 op/cycle per requester when its rsp_ready is held high.
- Pointer update:
  - last_grant <= granted index only on a cycle with a grant; otherwise it holds.
  - Neither requester waits more than one grant while continuously eligible.
- Reset values:
  - last_grant = 1, so requester 0 wins the first tie.
  - rsp_valid = 00, rsp_result = 0, rsp_zero = 00.
  - Consequently req_ready = 00 in the reset cycle.
- Reset mid-operation:
  - Any buffered response is discarded, and no grant is issued in a cycle where reset is high.
  - req_ready is forced to 00 while reset is high.
- Width rules: the result is passed through unmodified at WIDTH bits; there is no sign extension or truncation inside the block.
- Unused encodings: ALU ops 110/111 and funct3 codes other than 000/001/100/101 are forwarded unchanged; their meaning is defined by the ALU.

Test Plan:
- After reset, requester 0 only: A=5, B=3, ctl=000 -> req_ready=01 same cycle; next cycle rsp_valid=01, rsp_result[0]=8.
- Both requesters valid every cycle, rsp_ready=11:
  - requester 0 sub 10-4, requester 1 xor F0^0F;
  - grants alternate 0,1,0,1 starting with 0;
  - responses 6 and 0xFF appear one cycle after each grant.
- Requester 1 slt, A=0xFFFFFFFF, B=1, rsp_ready[1]=0 for 3 cycles:
  - rsp_result[1]=1 is held for all 3 cycles;
  - req_ready[1]=0 throughout; requester 0 is still granted every cycle.
- Requester 0 branch compare: A=7, B=7, funct3=000 -> rsp_zero[0]=1; then funct3=001 -> rsp_zero[0]=0.
- Back-to-back refill: rsp_valid[0]=1 and rsp_ready[0]=1 with a new request and 0 at 3 -> grant the same cycle; rsp_valid[0] stays 1 with result 3.
- Reset asserted while rsp_valid=11 -> next cycle rsp_valid=00, req_ready=00 during reset; first tie after reset is granted to requester 0.
